sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the successor to the fixed 8x8 FIFO, with configurable data width and depth. It adds programmable almost-full and almost-empty thresholds, a fill-count output, a read-valid strobe, a synchronous flush, and sticky error status with software clear. It sits between a producer and a consumer in one clock domain, and the existing directed stimulus bench drives it unchanged at default parameters.

---
 rtl/sync_fifo_pkg.sv | 35 +++
 rtl/fifo_mem_dp.sv | 46 ++++
 rtl/sync_fifo_param.sv | 187 ++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared constants and elaboration helpers for the
//               parametrised synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Default configuration, matching the original fixed 8x8 FIFO
    localparam int unsigned c_DEF_DATA_W    = 8;
    localparam int unsigned c_DEF_DEPTH     = 8;
    localparam int unsigned c_DEF_AF_THRESH = 7;
    localparam int unsigned c_DEF_AE_THRESH = 1;

    // Pointer width needed to address DEPTH entries
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // True when the parameter set describes a buildable FIFO
    function automatic bit params_legal(input int unsigned data_w,
                                        input int unsigned depth,
                                        input int unsigned af_thresh,
                                        input int unsigned ae_thresh);
        return (data_w >= 1) &&
               (depth >= 4) &&
               ((depth & (depth - 1)) == 0) &&
               (ae_thresh > 0) &&
               (ae_thresh < af_thresh) &&
               (af_thresh < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_dp.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem_dp
// Description : DEPTH x DATA_W register array, one write port and one
//               registered read port with read enable. Read returns the
//               pre-write contents when both ports hit the same slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_dp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds its value when no read is enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with fill count, programmable
//               almost-full/almost-empty flags, read-valid strobe, flush and
//               sticky overrun/underrun status with software clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = c_DEF_DATA_W,
    parameter int unsigned DEPTH     = c_DEF_DEPTH,
    parameter int unsigned AF_THRESH = c_DEF_AF_THRESH,
    parameter int unsigned AE_THRESH = c_DEF_AE_THRESH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_enb,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_enb,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   fifo_almost_full,
    output logic                   fifo_almost_empty,
    output logic                   fifo_overrun,
    output logic                   fifo_underrun,
    output logic                   ovr_sticky,
    output logic                   udr_sticky
);

    localparam int unsigned c_PTR_W = ptr_width(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF      = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_AE      = c_CNT_W'(AE_THRESH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Refuse to elaborate a FIFO whose thresholds or depth make no sense
    if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_overrun;
    logic               r_underrun;
    logic               r_ovr_sticky;
    logic               r_udr_sticky;
    logic               r_rd_valid;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_wr_do;
    logic               w_rd_do;
    logic               w_overrun;
    logic               w_underrun;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [DATA_W-1:0]  w_rd_data;

    // A full FIFO still takes a write when a read frees the oldest slot
    assign w_wr_acc = wr_enb & (~r_full | rd_enb);
    assign w_rd_acc = rd_enb & ~r_empty;

    // Reset and flush both swallow requests, so nothing touches storage
    assign w_wr_do = w_wr_acc & rst_n & ~flush;
    assign w_rd_do = w_rd_acc & rst_n & ~flush;

    // Error pulses only on edges where the request is actually evaluated
    assign w_overrun  = wr_enb & r_full & ~rd_enb & ~flush;
    assign w_underrun = rd_enb & r_empty & ~flush;

    // Next occupancy; flags are derived from this so they move with count
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_do && !w_rd_do) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_wr_do && w_rd_do) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_do) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_rd_do) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_DEPTH);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_AF);
            r_almost_empty <= (w_count_nxt <= c_AE);
        end
    end

    // Error pulses and sticky status; a new error beats a same-edge clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun    <= 1'b0;
            r_underrun   <= 1'b0;
            r_ovr_sticky <= 1'b0;
            r_udr_sticky <= 1'b0;
        end else begin
            r_overrun  <= w_overrun;
            r_underrun <= w_underrun;
            if (w_overrun) begin
                r_ovr_sticky <= 1'b1;
            end else if (err_clr) begin
                r_ovr_sticky <= 1'b0;
            end
            if (w_underrun) begin
                r_udr_sticky <= 1'b1;
            end else if (err_clr) begin
                r_udr_sticky <= 1'b0;
            end
        end
    end

    // Read-valid strobe marks the cycle after each accepted read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_do;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_do),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_do),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign rd_data           = w_rd_data;
    assign rd_valid          = r_rd_valid;
    assign fifo_count        = r_count;
    assign fifo_full         = r_full;
    assign fifo_empty        = r_empty;
    assign fifo_almost_full  = r_almost_full;
    assign fifo_almost_empty = r_almost_empty;
    assign fifo_overrun      = r_overrun;
    assign fifo_underrun     = r_underrun;
    assign ovr_sticky        = r_ovr_sticky;
    assign udr_sticky        = r_udr_sticky;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. Drives a default
//               8x8 instance and a 16x16 instance from the same stimulus and
//               compares both against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic        clk;
    logic        rst_n;
    logic        wr_enb;
    logic [15:0] wr_data;
    logic        rd_enb;
    logic        flush;
    logic        err_clr;

    logic [7:0]  a_rd;
    logic [3:0]  a_count;
    logic        a_val, a_full, a_empty, a_af, a_ae, a_ovr, a_udr, a_ovs, a_uds;
    logic [15:0] b_rd;
    logic [4:0]  b_count;
    logic        b_val, b_full, b_empty, b_af, b_ae, b_ovr, b_udr, b_ovs, b_uds;

    int n_chk = 0;
    int n_err = 0;

    sync_fifo_param u_dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_enb            (wr_enb),
        .wr_data           (wr_data[7:0]),
        .rd_enb            (rd_enb),
        .flush             (flush),
        .err_clr           (err_clr),
        .rd_data           (a_rd),
        .rd_valid          (a_val),
        .fifo_count        (a_count),
        .fifo_full         (a_full),
        .fifo_empty        (a_empty),
        .fifo_almost_full  (a_af),
        .fifo_almost_empty (a_ae),
        .fifo_overrun      (a_ovr),
        .fifo_underrun     (a_udr),
        .ovr_sticky        (a_ovs),
        .udr_sticky        (a_uds)
    );

    sync_fifo_param #(
        .DATA_W    (16),
        .DEPTH     (16),
        .AF_THRESH (12),
        .AE_THRESH (3)
    ) u_dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_enb            (wr_enb),
        .wr_data           (wr_data),
        .rd_enb            (rd_enb),
        .flush             (flush),
        .err_clr           (err_clr),
        .rd_data           (b_rd),
        .rd_valid          (b_val),
        .fifo_count        (b_count),
        .fifo_full         (b_full),
        .fifo_empty        (b_empty),
        .fifo_almost_full  (b_af),
        .fifo_almost_empty (b_ae),
        .fifo_overrun      (b_ovr),
        .fifo_underrun     (b_udr),
        .ovr_sticky        (b_ovs),
        .udr_sticky        (b_uds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model: one queue per instance ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          dep [2] = '{8, 16};
    int          afv [2] = '{7, 12};
    int          aev [2] = '{1, 3};
    logic [15:0] msk [2] = '{16'h00FF, 16'hFFFF};
    logic [15:0] e_rd  [2];
    logic        e_val [2];
    logic        e_ovr [2];
    logic        e_udr [2];
    logic        e_ovs [2];
    logic        e_uds [2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic qpush(input int k, input logic [15:0] d);
        if (k == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    task automatic qpop(input int k, output logic [15:0] d);
        if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
    endtask

    // Advance instance k by one clock edge using the inputs present at it
    task automatic model_step(input int k);
        int          n;
        bit          full, empty;
        logic [15:0] d;
        if (!rst_n) begin
            qclear(k);
            e_rd[k] = '0; e_val[k] = 0; e_ovr[k] = 0; e_udr[k] = 0;
            e_ovs[k] = 0; e_uds[k] = 0;
        end else if (flush) begin
            qclear(k);
            e_val[k] = 0; e_ovr[k] = 0; e_udr[k] = 0;
            if (err_clr) begin
                e_ovs[k] = 0; e_uds[k] = 0;
            end
        end else begin
            n     = qsize(k);
            full  = (n == dep[k]);
            empty = (n == 0);
            e_ovr[k] = wr_enb && full && !rd_enb;
            e_udr[k] = rd_enb && empty;
            e_val[k] = rd_enb && !empty;
            if (rd_enb && !empty) begin
                qpop(k, d);
                e_rd[k] = d;
            end
            if (wr_enb && (!full || rd_enb)) qpush(k, wr_data & msk[k]);
            if (e_ovr[k]) e_ovs[k] = 1; else if (err_clr) e_ovs[k] = 0;
            if (e_udr[k]) e_uds[k] = 1; else if (err_clr) e_uds[k] = 0;
        end
    endtask

    // {full, empty, almost_full, almost_empty, overrun, underrun, ovs, uds, valid}
    function automatic logic [8:0] exp_flags(input int k);
        int n;
        n = qsize(k);
        return {n == dep[k], n == 0, n >= afv[k], n <= aev[k],
                e_ovr[k], e_udr[k], e_ovs[k], e_uds[k], e_val[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("A.count",   32'(a_count), 32'(qsize(0)));
        check("A.flags",   32'({a_full, a_empty, a_af, a_ae, a_ovr, a_udr, a_ovs, a_uds, a_val}),
                           32'(exp_flags(0)));
        check("A.rd_data", 32'(a_rd), 32'(e_rd[0]));
        check("B.count",   32'(b_count), 32'(qsize(1)));
        check("B.flags",   32'({b_full, b_empty, b_af, b_ae, b_ovr, b_udr, b_ovs, b_uds, b_val}),
                           32'(exp_flags(1)));
        check("B.rd_data", 32'(b_rd), 32'(e_rd[1]));
    endtask

    // Apply one cycle of inputs, step the model at the edge, check 1ns later
    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic fl, input logic ec, input logic [15:0] d);
        rst_n = r; wr_enb = w; rd_enb = rd; flush = fl; err_clr = ec; wr_data = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0; flush = 1'b0; err_clr = 1'b0;
        wr_data = '0;

        // Reset for two edges
        cyc(0, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 0, 16'h0);
        check("rst.empty", 32'(a_empty), 32'd1);
        check("rst.ae",    32'(a_ae),    32'd1);
        check("rst.count", 32'(a_count), 32'd0);

        // Single transfer
        cyc(1, 1, 0, 0, 0, 16'h00A5);
        cyc(1, 0, 1, 0, 0, 16'h0);
        check("single.data",  32'(a_rd),    32'hA5);
        check("single.valid", 32'(a_val),   32'd1);
        check("single.empty", 32'(a_empty), 32'd1);
        cyc(1, 0, 0, 0, 0, 16'h0);
        check("single.valid_drop", 32'(a_val), 32'd0);

        // Fill to full, then one overrun attempt
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0, 0, 16'(8'h10 + i));
            check("fill.count", 32'(a_count), 32'(i + 1));
        end
        check("fill.full", 32'(a_full), 32'd1);
        cyc(1, 1, 0, 0, 0, 16'h00FF);
        check("ovr.pulse", 32'(a_ovr),   32'd1);
        check("ovr.count", 32'(a_count), 32'd8);
        cyc(1, 0, 0, 0, 0, 16'h0);
        check("ovr.once",   32'(a_ovr), 32'd0);
        check("ovr.sticky", 32'(a_ovs), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 1, 0, 0, 16'h0);
            check("drain.data", 32'(a_rd), 32'(8'h10 + i));
        end

        // Underrun, sticky clear, and clear colliding with a new underrun
        cyc(1, 0, 1, 0, 0, 16'h0);
        check("udr.pulse",  32'(a_udr), 32'd1);
        check("udr.sticky", 32'(a_uds), 32'd1);
        check("udr.hold",   32'(a_rd),  32'h17);
        cyc(1, 0, 0, 0, 1, 16'h0);
        check("udr.clear", 32'(a_uds), 32'd0);
        cyc(1, 0, 1, 0, 1, 16'h0);
        check("udr.set_wins", 32'(a_uds), 32'd1);

        // Full plus simultaneous write/read
        cyc(1, 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 16'(8'h20 + i));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 0, 16'(8'h30 + i));
            check("fullrw.data",  32'(a_rd),    32'(8'h20 + i));
            check("fullrw.count", 32'(a_count), 32'd8);
            check("fullrw.novr",  32'(a_ovr),   32'd0);
        end

        // Empty plus simultaneous write/read
        cyc(1, 0, 0, 1, 0, 16'h0);
        cyc(1, 1, 1, 0, 0, 16'h0042);
        check("emptyrw.count", 32'(a_count), 32'd1);
        check("emptyrw.udr",   32'(a_udr),   32'd1);
        check("emptyrw.noval", 32'(a_val),   32'd0);

        // Flush with five entries while a write is requested
        cyc(1, 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 16'(8'h40 + i));
        cyc(1, 1, 0, 1, 0, 16'h0099);
        check("flush.count", 32'(a_count), 32'd0);
        check("flush.empty", 32'(a_empty), 32'd1);
        check("flush.noerr", 32'({a_ovr, a_udr}), 32'd0);
        cyc(1, 1, 0, 0, 0, 16'h0055);
        cyc(1, 0, 1, 0, 0, 16'h0);
        check("flush.newdata", 32'(a_rd), 32'h55);

        // Reset with three entries held
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 16'(8'h60 + i));
        cyc(0, 1, 1, 0, 0, 16'h0);
        check("midrst.count", 32'(a_count), 32'd0);
        check("midrst.data",  32'(a_rd),    32'd0);
        check("midrst.flags", 32'({a_full, a_empty, a_af, a_ae, a_val, a_ovs, a_uds}),
                              32'b0101000);

        // Wide instance: threshold boundaries on fill and drain
        cyc(0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0, 0, 0, 16'($urandom));
            check("B.af_fill", 32'(b_af), 32'((i + 1) >= 12));
            check("B.ae_fill", 32'(b_ae), 32'((i + 1) <= 3));
        end
        for (int i = 15; i >= 0; i--) cyc(1, 0, 1, 0, 0, 16'h0);

        // Wide instance: 40 write/read pairs across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 0, 0, 16'($urandom));
            cyc(1, 0, 1, 0, 0, 16'h0);
        end

        // Randomised traffic with occasional flush, clear and reset
        for (int i = 0; i < 800; i++) begin
            logic w, r, fl, ec, rs;
            int   bias;
            bias = (i / 100) % 3;
            w  = ($urandom_range(0, 99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
            r  = ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
            fl = ($urandom_range(0, 63) == 0);
            ec = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 199) != 0);
            cyc(rs, w, r, fl, ec, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
